sram_data_responder: RTL

- Slave end of the CPU's data-SRAM interface. Services the en / wen[3:0] / addr / wdata requests issued by the core.
- Returns rdata with fixed 1-cycle latency.
- Decodes physical addresses (already translated by the MMU) into a local data RAM and a small configuration-register window: LED, switches, timer.
- Sits at SoC top level beside the instruction memory, in place of an external data SRAM.

---
 rtl/sram_data_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sram_data_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_data_responder
// Function : Data-SRAM slave with a local RAM and a LED/switch/timer register
//            window. Optional macro TIMER_IRQ_EN enables the timer compare IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module sram_data_responder #(
    parameter int unsigned ADDR_W  = 12,
    parameter logic [15:0] CONF_HI = 16'h1faf
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic        timer_irq
);

    localparam int unsigned DEPTH       = 2 ** ADDR_W;
    localparam logic [15:0] c_off_led   = 16'hf000;
    localparam logic [15:0] c_off_sw    = 16'hf004;
    localparam logic [15:0] c_off_timer = 16'hf008;
    localparam logic [15:0] c_off_cmp   = 16'hf00c;
    localparam logic [15:0] c_off_irq   = 16'hf010;

    logic [31:0]       rdata_q, rdata_d;
    logic [15:0]       led_q, led_d;
    logic [31:0]       timer_q, timer_d;
    logic [7:0]        sw_meta_q, sw_sync_q;

    logic [31:0]       w_mask;
    logic              w_is_wr;
    logic              w_conf;
    logic              w_conf_wr;
    logic              w_ram_wr;
    logic [15:0]       w_off;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_ram_word;
    logic [31:0]       w_conf_rd;
    logic [31:0]       w_cmp_post;
    logic              w_irq_cur;
    logic              w_irq_post;
    logic              w_unused;

    logic [31:0]       mem [DEPTH];

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_mask[8*i +: 8] = {8{data_sram_wen[i]}};
    end

    assign w_is_wr   = |data_sram_wen;
    assign w_conf    = (data_sram_addr[31:16] == CONF_HI);
    assign w_conf_wr = data_sram_en && w_conf && w_is_wr;
    assign w_ram_wr  = data_sram_en && !w_conf && w_is_wr;
    assign w_off     = {data_sram_addr[15:2], 2'b00};
    assign w_idx     = data_sram_addr[ADDR_W+1:2];
    assign w_unused  = ^data_sram_addr[1:0];

    // Merged word doubles as the write-first read value; with wen=0 it is the stored word.
    assign w_ram_word = (mem[w_idx] & ~w_mask) | (data_sram_wdata & w_mask);

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        led_d   = led_q;
        timer_d = timer_q + 32'd1;
        if (w_conf_wr && (w_off == c_off_led)) begin
            led_d = (led_q & ~w_mask[15:0]) | (data_sram_wdata[15:0] & w_mask[15:0]);
        end
        if (w_conf_wr && (w_off == c_off_timer)) begin
            timer_d = (timer_q & ~w_mask) | (data_sram_wdata & w_mask);
        end
    end

`ifdef TIMER_IRQ_EN
    logic [31:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;

    // Compare against the pre-increment timer; a match overrides a same-cycle clear.
    always_comb begin
        cmp_d = cmp_q;
        irq_d = irq_q;
        if (w_conf_wr && (w_off == c_off_cmp)) begin
            cmp_d = (cmp_q & ~w_mask) | (data_sram_wdata & w_mask);
        end
        if (w_conf_wr && (w_off == c_off_irq)) begin
            irq_d = 1'b0;
        end
        if (timer_q == cmp_q) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmp_q <= 32'd0;
            irq_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            irq_q <= irq_d;
        end
    end

    assign w_cmp_post = cmp_d;
    assign w_irq_cur  = irq_q;
    assign w_irq_post = irq_d;
    assign timer_irq  = irq_q;
`else
    assign w_cmp_post = 32'd0;
    assign w_irq_cur  = 1'b0;
    assign w_irq_post = 1'b0;
    assign timer_irq  = 1'b0;
`endif

    // Writes return the post-write register image; reads return the current one.
    always_comb begin
        w_conf_rd = 32'd0;
        case (w_off)
            c_off_led:   w_conf_rd = {16'd0, led_d};
            c_off_sw:    w_conf_rd = {24'd0, sw_sync_q};
            c_off_timer: w_conf_rd = w_is_wr ? timer_d : timer_q;
            c_off_cmp:   w_conf_rd = w_cmp_post;
            c_off_irq:   w_conf_rd = {31'd0, (w_is_wr ? w_irq_post : w_irq_cur)};
            default:     w_conf_rd = 32'd0;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (data_sram_en) begin
            rdata_d = w_conf ? w_conf_rd : w_ram_word;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= 32'd0;
            led_q     <= 16'd0;
            timer_q   <= 32'd0;
            sw_meta_q <= 8'd0;
            sw_sync_q <= 8'd0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            timer_q   <= timer_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;

endmodule
`default_nettype wire
